word_eq_compare: RTL and testbench

- Registered WIDTH-bit equality comparator. Default WIDTH is 4.
- The core computes a per-bit XOR difference. A NOR reduction of that difference produces `status` (1 when a == b).
- Used as the word-equality check in datapath/self-test logic. It adds a valid pipeline stage and saturating compare/mismatch counters for bench and BIST use.

---
 rtl/word_eq_pkg.sv | 9 +
 rtl/word_eq_core.sv | 16 +
 rtl/word_eq_compare.sv | 69 ++++++
 tb/tb_word_eq_compare.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/word_eq_pkg.sv
// Shared constants and types for the registered word-equality comparator.
package word_eq_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 4;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/word_eq_core.sv
// Combinational equality core: per-bit difference mask and its NOR reduction.
module word_eq_core
    import word_eq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] d,
    output logic             eq
);

    assign d  = a ^ b;
    assign eq = ~|d;

endmodule

// File: rtl/word_eq_compare.sv
// Registered WIDTH-bit equality comparator with a valid stage and
// saturating compare/mismatch counters for bench and self-test use.
module word_eq_compare
    import word_eq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic             status,
    output logic [WIDTH-1:0] diff,
    output logic [CNT_W-1:0] cmp_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] d;
    logic             eq;

    word_eq_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a (a),
        .b (b),
        .d (d),
        .eq(eq)
    );

    // status and diff hold their last captured value while in_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            status    <= 1'b0;
            diff      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                status <= eq;
                diff   <= d;
            end
        end
    end

    // Clear wins over a same-cycle compare, which is then not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_cnt <= '0;
            mis_cnt <= '0;
        end else if (cnt_clr) begin
            cmp_cnt <= '0;
            mis_cnt <= '0;
        end else if (in_valid) begin
            if (cmp_cnt != CNT_MAX) begin
                cmp_cnt <= cmp_cnt + 1'b1;
            end
            if (!eq && (mis_cnt != CNT_MAX)) begin
                mis_cnt <= mis_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_eq_compare.sv
// Self-checking bench for word_eq_compare: behavioural model checked every
// negedge, plus literal expectations at key points of the directed sequence.
module tb_word_eq_compare;
    import word_eq_pkg::*;

    localparam int CNT_MAX = 15;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  in_valid = 1'b0;
    word_t a = '0;
    word_t b = '0;
    logic  cnt_clr = 1'b0;
    logic  out_valid;
    logic  status;
    word_t diff;
    logic [3:0] cmp_cnt;
    logic [3:0] mis_cnt;

    int checks = 0;
    int errors = 0;

    int exp_valid = 0;
    int exp_status = 0;
    int exp_diff = 0;
    int exp_cmp = 0;
    int exp_mis = 0;

    word_eq_compare #(
        .WIDTH(4),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .cnt_clr  (cnt_clr),
        .out_valid(out_valid),
        .status   (status),
        .diff     (diff),
        .cmp_cnt  (cmp_cnt),
        .mis_cnt  (mis_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        exp_valid  = 0;
        exp_status = 0;
        exp_diff   = 0;
        exp_cmp    = 0;
        exp_mis    = 0;
    endtask

    // Drive one cycle of inputs on the negedge, then advance the model at the posedge
    task automatic applyStimulus(input int va, input int vb, input bit valid, input bit clr);
        int bits_differ;
        @(negedge clk);
        a        = word_t'(va);
        b        = word_t'(vb);
        in_valid = valid;
        cnt_clr  = clr;
        @(posedge clk);
        if (valid) begin
            exp_valid  = 1;
            exp_status = (va == vb) ? 1 : 0;
            bits_differ = 0;
            for (int i = 0; i < 4; i++) begin
                if (((va >> i) & 1) != ((vb >> i) & 1)) bits_differ += (1 << i);
            end
            exp_diff = bits_differ;
        end else begin
            exp_valid = 0;
        end
        if (clr) begin
            exp_cmp = 0;
            exp_mis = 0;
        end else if (valid) begin
            if (exp_cmp < CNT_MAX) exp_cmp++;
            if (va != vb && exp_mis < CNT_MAX) exp_mis++;
        end
    endtask

    task automatic checkLiteral(input string tag, input int v, input int s, input int d,
                                input int c, input int m);
        checkOutput({tag, ".out_valid"}, int'(out_valid), v);
        checkOutput({tag, ".status"}, int'(status), s);
        checkOutput({tag, ".diff"}, int'(diff), d);
        checkOutput({tag, ".cmp_cnt"}, int'(cmp_cnt), c);
        checkOutput({tag, ".mis_cnt"}, int'(mis_cnt), m);
    endtask

    always @(negedge clk) begin
        checkOutput("model.out_valid", int'(out_valid), exp_valid);
        checkOutput("model.status", int'(status), exp_status);
        checkOutput("model.diff", int'(diff), exp_diff);
        checkOutput("model.cmp_cnt", int'(cmp_cnt), exp_cmp);
        checkOutput("model.mis_cnt", int'(mis_cnt), exp_mis);
    end

    initial begin
        resetModel();
        #2;
        checkLiteral("reset", 0, 0, 0, 0, 0);
        #10 rst_n = 1'b1;

        applyStimulus(4'hA, 4'hA, 1'b1, 1'b0);
        #1 checkLiteral("eqA", 1, 1, 4'h0, 1, 0);
        applyStimulus(4'h0, 4'h1, 1'b1, 1'b0);
        #1 checkLiteral("ne01", 1, 0, 4'h1, 2, 1);
        applyStimulus(4'hF, 4'h7, 1'b1, 1'b0);
        #1 checkLiteral("neF7", 1, 0, 4'h8, 3, 2);

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                applyStimulus(ia, ib, 1'b1, 1'b0);
            end
        end
        #1 checkLiteral("sweep", 1, 1, 4'h0, 15, 15);

        for (int i = 0; i < 3; i++) applyStimulus(4'h3, 4'hC, 1'b0, 1'b0);
        #1 checkLiteral("idle", 0, 1, 4'h0, 15, 15);

        applyStimulus(4'h3, 4'h5, 1'b1, 1'b1);
        #1 checkLiteral("clr", 1, 0, 4'h6, 0, 0);

        applyStimulus(4'h2, 4'h2, 1'b1, 1'b0);
        applyStimulus(4'h1, 4'h2, 1'b1, 1'b0);
        #1 checkLiteral("pre_rst", 1, 0, 4'h3, 2, 1);

        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        resetModel();
        #1 checkLiteral("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        applyStimulus(4'h5, 4'h5, 1'b1, 1'b0);
        #1 checkLiteral("post_rst", 1, 1, 4'h0, 1, 0);
        applyStimulus(4'h9, 4'h6, 1'b1, 1'b0);
        #1 checkLiteral("post_rst2", 1, 0, 4'hF, 2, 1);
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
